// File: rtl/alu_src.sv
// ALU source selections, ALU opcodes and the ID/EX register bundle shared
// by the decode, forwarding and execute stages.
package alu_src;

  // Datapath width the ID/EX bundle is laid out for; id_ex_stage's XLEN must match.
  localparam int unsigned XLEN_PKG  = 32;
  localparam int unsigned REG_IDX_W = 5;

  // Operand source for paths that never take the immediate (rs1, store data).
  typedef enum logic [1:0] {
    NI_REG = 2'd0,
    NI_MEM = 2'd1,
    NI_WB  = 2'd2
  } NonImmAluSrc;

  // Operand source for ALU input B, which may also be the immediate.
  typedef enum logic [1:0] {
    AS_REG = 2'd0,
    AS_MEM = 2'd1,
    AS_WB  = 2'd2,
    AS_IMM = 2'd3
  } AluSrc;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } AluOp;

  localparam AluOp ALU_OP_ADD = ALU_ADD;

  // Everything the EX stage receives from ID, registered as one word.
  typedef struct packed {
    logic                   vld;
    logic [REG_IDX_W-1:0]   rd;
    logic                   reg_w_en;
    logic                   mem_r_en;
    logic                   mem_w_en;
    AluOp                   alu_op;
    logic [XLEN_PKG-1:0]    imm;
    logic [XLEN_PKG-1:0]    rs1_data;
    logic [XLEN_PKG-1:0]    rs2_data;
    NonImmAluSrc            alu_src_a;
    AluSrc                  alu_src_b;
    NonImmAluSrc            data_mem_src;
  } IdExBundle;

  // A bubble: no side effects, register sources, zero data, ADD.
  localparam IdExBundle ID_EX_BUBBLE = '{
    vld:          1'b0,
    rd:           '0,
    reg_w_en:     1'b0,
    mem_r_en:     1'b0,
    mem_w_en:     1'b0,
    alu_op:       ALU_OP_ADD,
    imm:          '0,
    rs1_data:     '0,
    rs2_data:     '0,
    alu_src_a:    NI_REG,
    alu_src_b:    AS_REG,
    data_mem_src: NI_REG
  };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose result is read by the
// instruction in ID cannot be forwarded in time and needs one bubble.
module load_use_detect
  import alu_src::*;
(
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_imm,
  input  logic                 id_mem_w_en,
  input  logic                 ex_valid,
  input  logic                 ex_mem_r_en,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 lu
);

  // rs2 is only a real source when the immediate does not replace it,
  // except for stores, which always read rs2 as the store data.
  logic rs2_read;
  logic ex_load;

  assign rs2_read = ~id_use_imm | id_mem_w_en;
  assign ex_load  = ex_valid & ex_mem_r_en & (ex_rd != '0);
  assign lu       = id_valid & ex_load &
                    ((id_rs1 == ex_rd) | ((id_rs2 == ex_rd) & rs2_read));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating count of inserted load-use bubbles.
module id_ex_stage
  import alu_src::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_id_valid,
  input  logic [4:0]           i_id_rs1,
  input  logic [4:0]           i_id_rs2,
  input  logic [4:0]           i_id_rd,
  input  logic                 i_id_reg_w_en,
  input  logic                 i_id_mem_r_en,
  input  logic                 i_id_mem_w_en,
  input  logic                 i_id_use_imm,
  input  logic [3:0]           i_id_alu_op,
  input  logic [XLEN-1:0]      i_id_imm,
  input  logic [XLEN-1:0]      i_id_rs1_data,
  input  logic [XLEN-1:0]      i_id_rs2_data,
  input  NonImmAluSrc          i_alu_src_a,
  input  NonImmAluSrc          i_data_mem_src,
  input  AluSrc                i_alu_src_b,
  input  logic                 i_flush,
  input  logic                 i_hold,
  output logic                 o_stall,
  output logic                 o_ex_valid,
  output logic [4:0]           o_ex_rd,
  output logic                 o_ex_reg_w_en,
  output logic                 o_ex_mem_r_en,
  output logic                 o_ex_mem_w_en,
  output logic [3:0]           o_ex_alu_op,
  output logic [XLEN-1:0]      o_ex_imm,
  output logic [XLEN-1:0]      o_ex_rs1_data,
  output logic [XLEN-1:0]      o_ex_rs2_data,
  output NonImmAluSrc          o_ex_alu_src_a,
  output AluSrc                o_ex_alu_src_b,
  output NonImmAluSrc          o_ex_data_mem_src,
  output logic [CNT_W-1:0]     o_bubble_cnt
);

  IdExBundle        id_p0;
  IdExBundle        ex_p1;
  logic             lu_p0;
  logic [CNT_W-1:0] bubble_cnt_p1;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---- ID stage (p0): hazard check against the instruction now in EX ----
  load_use_detect u_load_use_detect (
    .id_valid    (i_id_valid),
    .id_rs1      (i_id_rs1),
    .id_rs2      (i_id_rs2),
    .id_use_imm  (i_id_use_imm),
    .id_mem_w_en (i_id_mem_w_en),
    .ex_valid    (ex_p1.vld),
    .ex_mem_r_en (ex_p1.mem_r_en),
    .ex_rd       (ex_p1.rd),
    .lu          (lu_p0)
  );

  // A redirect cancels the ID instruction, so freezing IF/ID would be wrong.
  assign o_stall = (lu_p0 | i_hold) & ~i_flush;

  // Bundle the ID fields; side-effecting enables only survive with valid.
  always_comb begin
    id_p0              = ID_EX_BUBBLE;
    id_p0.vld          = i_id_valid;
    id_p0.rd           = i_id_rd;
    id_p0.reg_w_en     = i_id_reg_w_en & i_id_valid;
    id_p0.mem_r_en     = i_id_mem_r_en & i_id_valid;
    id_p0.mem_w_en     = i_id_mem_w_en & i_id_valid;
    id_p0.alu_op       = AluOp'(i_id_alu_op);
    id_p0.imm          = i_id_imm;
    id_p0.rs1_data     = i_id_rs1_data;
    id_p0.rs2_data     = i_id_rs2_data;
    id_p0.alu_src_a    = i_alu_src_a;
    id_p0.alu_src_b    = i_alu_src_b;
    id_p0.data_mem_src = i_data_mem_src;
  end

  // ---- EX stage (p1): flush > hold > load-use bubble > capture ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_p1         <= ID_EX_BUBBLE;
      bubble_cnt_p1 <= '0;
    end else if (i_flush) begin
      ex_p1 <= ID_EX_BUBBLE;
    end else if (!i_hold) begin
      if (lu_p0) begin
        ex_p1         <= ID_EX_BUBBLE;
        bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
      end else begin
        ex_p1 <= id_p0;
      end
    end
  end

  assign o_ex_valid        = ex_p1.vld;
  assign o_ex_rd           = ex_p1.rd;
  assign o_ex_reg_w_en     = ex_p1.reg_w_en;
  assign o_ex_mem_r_en     = ex_p1.mem_r_en;
  assign o_ex_mem_w_en     = ex_p1.mem_w_en;
  assign o_ex_alu_op       = ex_p1.alu_op;
  assign o_ex_imm          = ex_p1.imm;
  assign o_ex_rs1_data     = ex_p1.rs1_data;
  assign o_ex_rs2_data     = ex_p1.rs2_data;
  assign o_ex_alu_src_a    = ex_p1.alu_src_a;
  assign o_ex_alu_src_b    = ex_p1.alu_src_b;
  assign o_ex_data_mem_src = ex_p1.data_mem_src;
  assign o_bubble_cnt      = bubble_cnt_p1;

endmodule
